// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA key-pair inverter scheduler.
//   - scheduler state encodings (2-bit)
//   - default operand width and requester-id width
package rsa_pkg;

  localparam int unsigned RSA_WIDTH = 32;
  localparam int unsigned ID_W      = 1;

  localparam logic [1:0] IDLE_ENC  = 2'd0;
  localparam logic [1:0] START_ENC = 2'd1;
  localparam logic [1:0] WAIT_ENC  = 2'd2;
  localparam logic [1:0] RESP_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE_ENC,
    ST_START = START_ENC,
    ST_WAIT  = WAIT_ENC,
    ST_RESP  = RESP_ENC
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk, rst_n  : clock, async active-low reset (last grant resets to 1)
//   valid_i     : request vector
//   advance_i   : grant is being consumed this cycle; remember the winner
//   grant_c     : one-hot grant (combinational)
//   id_c        : index of the granted requester (combinational)
module rr_arb2
  import rsa_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      valid_i,
  input  logic            advance_i,
  output logic [1:0]      grant_c,
  output logic [ID_W-1:0] id_c
);

  logic last_q, last_d;

  // Lone requester wins; on a tie the one that did not win last time wins.
  always_comb begin
    grant_c = 2'b00;
    unique case (valid_i)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last_q ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
    id_c   = ID_W'(grant_c[1]);
    last_d = advance_i ? grant_c[1] : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/rsa_keygen_sched.sv
// Scheduler sharing one RSA modular-inverse unit between two requesters.
// Accepts operands round-robin, rejects degenerate primes, pulses the
// inverter start, waits for finish with a timeout, and returns e/d (or an
// error) on a valid/ready response channel tagged with the requester id.
// Ports:
//   clk, reset                 : clock, async active-low reset
//   reqN_valid/p/q, reqN_ready : requester N operand channel (ready comb.)
//   inv_p/q, inv_start         : operands and start pulse to the inverter
//   inv_finish, inv_e, inv_d   : inverter results
//   rsp_valid/ready/id/err/e/d : response channel
//   busy                       : scheduler not idle
// Optional (RSA_SCHED_STATS_EN): stat_ok/stat_err/stat_timeout saturating
// 16-bit response counters.
module rsa_keygen_sched
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH          = RSA_WIDTH,
  parameter int unsigned START_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [WIDTH-1:0]     req0_p,
  input  logic [WIDTH-1:0]     req0_q,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [WIDTH-1:0]     req1_p,
  input  logic [WIDTH-1:0]     req1_q,
  output logic                 req1_ready,
  output logic [WIDTH-1:0]     inv_p,
  output logic [WIDTH-1:0]     inv_q,
  output logic                 inv_start,
  input  logic                 inv_finish,
  input  logic [WIDTH-1:0]     inv_e,
  input  logic [2*WIDTH-1:0]   inv_d,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic                 rsp_err,
  output logic [WIDTH-1:0]     rsp_e,
  output logic [2*WIDTH-1:0]   rsp_d,
  output logic                 busy
`ifdef RSA_SCHED_STATS_EN
  ,
  output logic [15:0]          stat_ok,
  output logic [15:0]          stat_err,
  output logic [15:0]          stat_timeout
`endif
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + START_CYCLES + 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     p_q, p_d, q_q, q_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 err_q, err_d;
  logic                 to_q, to_d;
  logic [WIDTH-1:0]     e_q, e_d;
  logic [2*WIDTH-1:0]   d_q, d_d;
  logic                 start_q, valid_q, busy_q;

  logic [1:0]           arb_valid, grant;
  logic [ID_W-1:0]      arb_id;
  logic                 accept;
  logic [WIDTH-1:0]     sel_p, sel_q;
  logic                 operands_ok;

  assign arb_valid = {req1_valid, req0_valid} & {2{state_q == ST_IDLE}};

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (reset),
    .valid_i   (arb_valid),
    .advance_i (accept),
    .grant_c   (grant),
    .id_c      (arb_id)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // The check sees exactly the operands being latched this cycle.
  assign sel_p       = grant[1] ? req1_p : req0_p;
  assign sel_q       = grant[1] ? req1_q : req0_q;
  assign operands_ok = (sel_p >= WIDTH'(2)) && (sel_q >= WIDTH'(2)) && (sel_p != sel_q);

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    id_d    = id_q;
    err_d   = err_q;
    to_d    = to_q;
    e_d     = e_q;
    d_d     = d_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (|grant) begin
          accept = 1'b1;
          p_d    = sel_p;
          q_d    = sel_q;
          id_d   = arb_id;
          cnt_d  = '0;
          if (operands_ok) begin
            state_d = ST_START;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            to_d    = 1'b0;
            e_d     = '0;
            d_d     = '0;
          end
        end
      end
      ST_START: begin
        if (cnt_q == START_LAST) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        // Finish takes priority over a coincident timeout.
        if (inv_finish) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          to_d    = 1'b0;
          e_d     = inv_e;
          d_d     = inv_d;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          to_d    = 1'b1;
          e_d     = '0;
          d_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
      e_q     <= '0;
      d_q     <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      id_q    <= id_d;
      err_q   <= err_d;
      to_q    <= to_d;
      e_q     <= e_d;
      d_q     <= d_d;
      start_q <= (state_d == ST_START);
      valid_q <= (state_d == ST_RESP);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign inv_p     = p_q;
  assign inv_q     = q_q;
  assign inv_start = start_q;
  assign rsp_valid = valid_q;
  assign rsp_id    = id_q[0];
  assign rsp_err   = err_q;
  assign rsp_e     = e_q;
  assign rsp_d     = d_q;
  assign busy      = busy_q;

`ifdef RSA_SCHED_STATS_EN
  logic        rsp_hs;
  logic [15:0] ok_q, errc_q, toc_q;

  assign rsp_hs = valid_q & rsp_ready;

  // Saturating per-outcome counters, bumped on each response handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ok_q   <= '0;
      errc_q <= '0;
      toc_q  <= '0;
    end else if (rsp_hs) begin
      if (!err_q && ok_q != 16'hFFFF)          ok_q   <= ok_q + 16'd1;
      if (err_q && errc_q != 16'hFFFF)         errc_q <= errc_q + 16'd1;
      if (err_q && to_q && toc_q != 16'hFFFF)  toc_q  <= toc_q + 16'd1;
    end
  end

  assign stat_ok      = ok_q;
  assign stat_err     = errc_q;
  assign stat_timeout = toc_q;
`endif

endmodule

// File: tb/tb_rsa_keygen_sched.sv
module tb_rsa_keygen_sched;

  localparam int unsigned W  = 32;
  localparam int unsigned SC = 1;
  localparam int unsigned TO = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [W-1:0]     req0_p, req0_q, req1_p, req1_q;
  logic             req0_ready, req1_ready;
  logic [W-1:0]     inv_p, inv_q;
  logic             inv_start;
  logic             inv_finish;
  logic [W-1:0]     inv_e;
  logic [2*W-1:0]   inv_d;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [W-1:0]     rsp_e;
  logic [2*W-1:0]   rsp_d;
`ifdef RSA_SCHED_STATS_EN
  logic [15:0]      stat_ok, stat_err, stat_timeout;
`endif

  rsa_keygen_sched #(.WIDTH(W), .START_CYCLES(SC), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_p     (req0_p),
    .req0_q     (req0_q),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_p     (req1_p),
    .req1_q     (req1_q),
    .req1_ready (req1_ready),
    .inv_p      (inv_p),
    .inv_q      (inv_q),
    .inv_start  (inv_start),
    .inv_finish (inv_finish),
    .inv_e      (inv_e),
    .inv_d      (inv_d),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err),
    .rsp_e      (rsp_e),
    .rsp_d      (rsp_d),
    .busy       (busy)
`ifdef RSA_SCHED_STATS_EN
    ,
    .stat_ok      (stat_ok),
    .stat_err     (stat_err),
    .stat_timeout (stat_timeout)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int mon_viol = 0;
  int last_hs = 0;
  int exp_last = 1;

  // Per-requester transaction description
  logic [W-1:0]   op_p [2];
  logic [W-1:0]   op_q [2];
  int             op_fd [2];
  logic [W-1:0]   op_e [2];
  logic [2*W-1:0] op_d [2];

  // Inverter model: finish rises fin_delay WAIT-cycles after start drops.
  int fin_delay = -1;
  int wcnt = 0;
  bit started = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      started = 0; wcnt = 0; inv_finish = 1'b0;
    end else if (inv_start) begin
      started = 1; wcnt = 0; inv_finish = 1'b0;
    end else if (started) begin
      wcnt++;
      inv_finish = (fin_delay > 0) && (wcnt >= fin_delay);
    end
  end

  // Protocol monitor: ready exclusivity, ready only when idle and requested.
  always @(negedge clk) begin
    if (reset) begin
      if (inv_start) start_cnt++;
      if ((req0_ready && req1_ready) || ((req0_ready || req1_ready) && busy) ||
          (req0_ready && !req0_valid) || (req1_ready && !req1_valid))
        mon_viol++;
    end
  end

  function automatic int rr_pick(input bit v0, input bit v1);
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    return (exp_last == 1) ? 0 : 1;
  endfunction

  task automatic apply(input int id, input logic [W-1:0] p, input logic [W-1:0] q, input int fd);
    op_p[id] = p; op_q[id] = q; op_fd[id] = fd;
    op_e[id] = $urandom;
    op_d[id] = {$urandom, $urandom};
    if (id == 0) begin req0_p = p; req0_q = q; req0_valid = 1'b1; end
    else         begin req1_p = p; req1_q = q; req1_valid = 1'b1; end
  endtask

  function automatic logic [W-1:0] rand_prime_like();
    return W'($urandom_range(2, 5000));
  endfunction

  // Wait for a grant, then check the whole transaction against the model.
  task automatic serve(input int exp_id, input int hold, input bit drop, input bit chk_b2b,
                       output logic [W-1:0] oe, output logic [2*W-1:0] od);
    bit got = 0;
    int a, r, id, s0, lat, fd;
    logic [W-1:0] p, q, ee;
    logic [2*W-1:0] ed;
    logic eerr;
    oe = '0; od = '0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL accept_wait: no ready within 300 cycles, required grant to %0d", exp_id);
      return;
    end
    a = cyc;
    id = req1_ready ? 1 : 0;
    checks++;
    if (id !== exp_id) begin
      errors++; $display("FAIL grant: got requester %0d, required %0d", id, exp_id);
    end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_at_accept: rsp_valid=%0b busy=%0b, required 0 0", rsp_valid, busy);
    end
    if (chk_b2b) begin
      checks++;
      if (a !== last_hs + 1) begin
        errors++; $display("FAIL b2b_accept: accept %0d cycles after handshake, required 1", a - last_hs);
      end
    end
    exp_last = exp_id;
    p = op_p[id]; q = op_q[id]; fd = op_fd[id];
    // Expected outcome from the scheduling rules
    if (p < 2 || q < 2 || p == q) begin
      lat = 1; eerr = 1'b1; ee = '0; ed = '0;
    end else if (fd >= 1 && fd <= int'(TO)) begin
      lat = int'(SC) + fd + 1; eerr = 1'b0; ee = op_e[id]; ed = op_d[id];
    end else begin
      lat = int'(SC) + int'(TO) + 1; eerr = 1'b1; ee = '0; ed = '0;
    end
    @(posedge clk); #1;
    s0 = start_cnt;
    fin_delay = fd; inv_e = op_e[id]; inv_d = op_d[id];
    if (drop) begin
      if (id == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    end else begin
      apply(id, rand_prime_like(), rand_prime_like(), int'($urandom_range(1, 20)));
    end
    got = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL rsp_wait: no rsp_valid within 200 cycles (requester %0d)", id);
      return;
    end
    r = cyc;
    checks++;
    if (r - a !== lat) begin
      errors++; $display("FAIL latency: rsp_valid %0d cycles after accept, required %0d", r - a, lat);
    end
    checks++;
    if (rsp_id !== 1'(id) || rsp_err !== eerr) begin
      errors++; $display("FAIL rsp_tag: id=%0d err=%0b, required id=%0d err=%0b", rsp_id, rsp_err, id, eerr);
    end
    checks++;
    if (rsp_e !== ee || rsp_d !== ed) begin
      errors++; $display("FAIL rsp_data: e=%h d=%h, required e=%h d=%h", rsp_e, rsp_d, ee, ed);
    end
    checks++;
    if (inv_p !== p || inv_q !== q) begin
      errors++; $display("FAIL inv_ops: p=%0d q=%0d, required p=%0d q=%0d", inv_p, inv_q, p, q);
    end
    checks++;
    if (start_cnt - s0 !== ((lat == 1) ? 0 : int'(SC))) begin
      errors++; $display("FAIL start_len: inv_start high %0d cycles, required %0d",
                         start_cnt - s0, (lat == 1) ? 0 : int'(SC));
    end
    oe = rsp_e; od = rsp_d;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      checks++;
      if (!rsp_valid || rsp_e !== ee || rsp_d !== ed || rsp_err !== eerr || rsp_id !== 1'(id) ||
          req0_ready || req1_ready) begin
        errors++; $display("FAIL hold: cycle %0d valid=%0b e=%h err=%0b rdy=%0b%0b, required stable response, no ready",
                           h, rsp_valid, rsp_e, rsp_err, req1_ready, req0_ready);
      end
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    last_hs = cyc;
    @(posedge clk); #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_p = '0; req0_q = '0; req1_p = '0; req1_q = '0;
    inv_e = '0; inv_d = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({inv_start, rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready} !== 7'b0 ||
        inv_p !== '0 || inv_q !== '0 || rsp_e !== '0 || rsp_d !== '0) begin
      errors++; $display("FAIL reset_outputs: start=%0b valid=%0b err=%0b busy=%0b p=%0d, required all 0",
                         inv_start, rsp_valid, rsp_err, busy, inv_p);
    end
    reset = 1'b1;
    exp_last = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic [W-1:0] e; logic [2*W-1:0] d;
    logic [127:0] prod;
    apply(0, 23, 5, 3);
    op_e[0] = 3; op_d[0] = 59;
    serve(0, 0, 1, 0, e, d);
    prod = 128'(e) * 128'(d);
    checks++;
    if (prod % 88 !== 1) begin
      errors++; $display("FAIL ed_mod_phi: (e*d) mod 88 = %0d, required 1", prod % 88);
    end
  endtask

  task automatic test_bad_operands();
    logic [W-1:0] e; logic [2*W-1:0] d;
    logic [W-1:0] x;
    apply(0, 7, 7, 2);   serve(rr_pick(1, 0), 0, 1, 0, e, d);
    apply(1, 1, 13, 2);  serve(rr_pick(0, 1), 0, 1, 0, e, d);
    apply(0, 0, 0, 2);   serve(rr_pick(1, 0), 0, 1, 0, e, d);
    x = rand_prime_like();
    apply(1, x, x, 2);   serve(rr_pick(0, 1), 0, 1, 0, e, d);
  endtask

  task automatic test_timeout();
    logic [W-1:0] e; logic [2*W-1:0] d;
    apply(0, 11, 13, -1);     serve(rr_pick(1, 0), 0, 1, 0, e, d);
    apply(0, 11, 13, TO);     serve(rr_pick(1, 0), 0, 1, 0, e, d);
    apply(1, 17, 19, TO + 1); serve(rr_pick(0, 1), 0, 1, 0, e, d);
    apply(1, 2, 3, 1);        serve(rr_pick(0, 1), 0, 1, 0, e, d);
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e; logic [2*W-1:0] d;
    int first;
    apply(0, 29, 31, 2);
    apply(1, 37, 41, 4);
    first = rr_pick(1, 1);
    serve(first, 10, 1, 0, e, d);
    serve(1 - first, 3, 1, 1, e, d);
  endtask

  task automatic test_random();
    logic [W-1:0] e; logic [2*W-1:0] d;
    logic [W-1:0] p, q;
    int id;
    for (int i = 0; i < 6; i++) begin
      id = int'($urandom_range(0, 1));
      p = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 3)) : rand_prime_like();
      q = ($urandom_range(0, 3) == 0) ? p : rand_prime_like();
      apply(id, p, q, int'($urandom_range(1, 20)));
      serve(id, int'($urandom_range(0, 3)), 1, 0, e, d);
    end
  endtask

  task automatic test_reset_mid_wait();
    bit got = 0;
    apply(1, 43, 47, -1);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (req1_ready) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL midwait_accept: req1 not accepted within 50 cycles");
    end
    @(posedge clk); #1;
    req1_valid = 1'b0; fin_delay = -1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({inv_start, rsp_valid, rsp_id, rsp_err, busy, req0_ready, req1_ready} !== 7'b0 ||
        inv_p !== '0 || inv_q !== '0 || rsp_e !== '0 || rsp_d !== '0) begin
      errors++; $display("FAIL midwait_reset: busy=%0b valid=%0b p=%0d q=%0d, required all 0",
                         busy, rsp_valid, inv_p, inv_q);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    exp_last = 1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e; logic [2*W-1:0] d;
    @(posedge clk); #1;
    apply(0, rand_prime_like(), 3, int'($urandom_range(1, 8)));
    apply(1, 5, rand_prime_like() + 5, int'($urandom_range(1, 8)));
    for (int i = 0; i < 4; i++) begin
      serve(rr_pick(1, 1), 0, 0, i > 0, e, d);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_monitor();
    checks++;
    if (mon_viol !== 0) begin
      errors++; $display("FAIL ready_protocol: %0d violating cycles, required 0", mon_viol);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_bad_operands();
    test_timeout();
    test_backpressure();
    test_random();
    test_reset_mid_wait();
    test_back_to_back();
    test_monitor();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_keygen_sched.md
Name: rsa_keygen_sched

Overview:
- Scheduler that shares one RSA key-pair inverter (modular inverse unit: p, q in; finish, e, d out) between two requesters.
- Round-robin arbitrates requests and validates operands.
- Launches the inverter with a start pulse on its reset input and waits for finish, with a timeout.
- Returns e/d (or an error) through a valid/ready response channel tagged with the requester id.

Parameters:
- WIDTH, 32: operand/e width; d is 2*WIDTH.
- START_CYCLES, 1: cycles inv_start is held high (min 1).
- TIMEOUT_CYCLES, 4096: max WAIT cycles before an error response (min 2).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has operands.
- req0_p, req0_q  in  WIDTH each  requester 0 primes.
- req0_ready  out  1  requester 0 accepted this cycle.
- req1_valid, req1_p, req1_q, req1_ready: as req0, for requester 1.
- inv_p, inv_q  out  WIDTH  operands to the inverter, stable from accept until the next accept.
- inv_start  out  1  drives the inverter reset/start input.
- inv_finish  in  1  inverter done.
- inv_e  in  WIDTH  public exponent.
- inv_d  in  2*WIDTH  private exponent.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester the response belongs to.
- rsp_err  out  1  1 = bad operands or timeout.
- rsp_e  out  WIDTH  captured e.
- rsp_d  out  2*WIDTH  captured d.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE. All outputs 0. last_grant=1, so requester 0 wins the first tie. Timeout counter=0. A reset mid-operation aborts with no response; the inverter is left as is.
- IDLE:
  - Grant = only valid requester, else the one != last_grant.
  - In the grant cycle: reqN_ready=1 (combinational from state+valid); latch p, q, id; last_grant=id.
  - ready is never high for both requesters, and never high outside IDLE.
  - Operand check uses the latched values: p<2, q<2, or p==q -> RESP with err=1, e=d=0, inverter not started.
  - Otherwise -> START.
- START: inv_start=1 for exactly START_CYCLES cycles, then -> WAIT with counter=0.
- WAIT:
  - inv_finish is sampled from the first WAIT cycle.
  - The start pulse clears the inverter, so a stale finish is impossible.
  - finish=1: capture inv_e/inv_d into rsp_e/rsp_d, err=0 -> RESP.
  - Else counter++; when the counter reaches TIMEOUT_CYCLES-1 without finish -> RESP with err=1, e=d=0.
  - If finish and timeout occur in the same cycle, finish wins.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_valid & rsp_ready.
  - Then -> IDLE; rsp_valid drops the next cycle.
  - No new accept in the handshake cycle; earliest accept is the cycle after returning to IDLE.
- Latency, valid operands:
  - accept cycle A; inv_start high A+1..A+START_CYCLES.
  - rsp_valid rises the cycle after finish is sampled.
  - Bad operands: rsp_valid at A+1.
- Widths: all comparisons unsigned; no arithmetic on e/d (pass-through).

Optional Feature:
- RSA_SCHED_STATS_EN defined:
  - Adds outputs stat_ok (16), stat_err (16), stat_timeout (16).
  - Counted at each response handshake.
  - Saturating at 16'hFFFF; cleared by reset.
  - stat_timeout counts only timeouts; stat_err counts all errors.
- Undefined: these ports and counters are absent; behaviour otherwise identical.

Decomposition:
- Shared package rsa_pkg:
  - state encodings IDLE/START/WAIT/RESP (2-bit localparams);
  - default WIDTH;
  - requester-id width.
- Sub-module rr_arb2:
  - 2-way round-robin: valid[1:0] + last_grant in, one-hot grant + id out;
  - combinational plus the last_grant register.

Test Plan:
- Single request: req0 p=23, q=5 -> inv_start high 1 cycle; inverter (real or model) finishes; rsp_valid, id=0, err=0, rsp_e/rsp_d = inverter outputs, (rsp_e*rsp_d) mod 88 == 1.
- Contention: req0 and req1 valid together, then back-to-back -> grants 0,1,0,1; ready never high for both; rsp_id order matches.
- Bad operands: p=7, q=7, then p=1, q=13 -> rsp_valid 1 cycle after accept, err=1, e=d=0, inv_start stays 0.
- Timeout: model never asserts finish, TIMEOUT_CYCLES=16 -> err=1 exactly 16 WAIT cycles after START ends; finish asserted on cycle 16 -> err=0.
- Backpressure: rsp_ready low 10 cycles -> rsp_* stable, req1_ready stays 0 while req1_valid=1, accept one cycle after the handshake.
- Reset mid-WAIT: drop reset for 2 cycles -> all outputs 0 immediately, IDLE, req0 wins the next tie.
